// File: rtl/irq_arbiter.sv
// irq_arbiter: interrupt request arbiter with a PDP-8 style IOT control interface.
//
// Each request line is synchronised and then treated either as a level or as a
// rising-edge sticky request (EDGE_MASK). Requests are qualified by MASK to form
// PENDING. A four-state controller (DISABLED/ARMING/ENABLED/TAKEN) decides when
// an interrupt may be taken at an instruction boundary (STB_FETCH). The lowest
// pending channel wins.
//
// Optional feature: define IRQ_ARBITER_MASK_EN to build the loadable MASK
// register (LDMASK). Without it MASK is constant all ones and LDMASK is a no-op.
//
// Ports:
//   SYSCLK        in   system clock
//   RESET_N       in   asynchronous active-low reset
//   IRQ[NCH]      in   raw request lines (asynchronous)
//   IOT_EN        in   IOT strobe for this block
//   IOT_OP[3]     in   IOT function code
//   AC[12]        in   accumulator operand
//   STB_FETCH     in   instruction boundary pulse
//   IE            out  interrupts enabled
//   IRQ_OVERRIDE  out  force current instruction to JMS 0000
//   ACK           out  one-cycle pulse on entry to TAKEN
//   VECTOR[4]     out  serviced channel index
//   PENDING[NCH]  out  masked pending requests
//   SKIP          out  combinational skip request
//   DOUT[12]      out  RDVEC read data
module irq_arbiter #(
  parameter int unsigned     NCH         = 4,
  parameter int unsigned     SYNC_STAGES = 2,
  parameter logic [NCH-1:0]  EDGE_MASK   = '0
) (
  input  logic             SYSCLK,
  input  logic             RESET_N,
  input  logic [NCH-1:0]   IRQ,
  input  logic             IOT_EN,
  input  logic [2:0]       IOT_OP,
  input  logic [11:0]      AC,
  input  logic             STB_FETCH,
  output logic             IE,
  output logic             IRQ_OVERRIDE,
  output logic             ACK,
  output logic [3:0]       VECTOR,
  output logic [NCH-1:0]   PENDING,
  output logic             SKIP,
  output logic [11:0]      DOUT
);

  localparam logic [2:0] OpSkon    = 3'd0;
  localparam logic [2:0] OpIon     = 3'd1;
  localparam logic [2:0] OpIof     = 3'd2;
  localparam logic [2:0] OpSrq     = 3'd3;
  localparam logic [2:0] OpLdmask  = 3'd4;
  localparam logic [2:0] OpRdvec   = 3'd5;
  localparam logic [2:0] OpClrpend = 3'd6;

  typedef enum logic [1:0] {StDisabled, StArming, StEnabled, StTaken} state_e;

  state_e                            state_q, state_d;
  logic [SYNC_STAGES-1:0][NCH-1:0]   sync_q, sync_d;
  logic [NCH-1:0]                    prev_q;
  logic [NCH-1:0]                    sticky_q, sticky_d;
  logic [3:0]                        vector_q, vector_d;
  logic                              ack_q, ack_d;

  logic [NCH-1:0] sync_out;
  logic [NCH-1:0] rise;
  logic [NCH-1:0] mask;
  logic [NCH-1:0] pending;
  logic [NCH-1:0] clr;
  logic [3:0]     low_idx;
  logic           take;
  logic           iot_ion;
  logic           iot_off;
  logic           iot_clrpend;

  assign iot_ion     = IOT_EN && (IOT_OP == OpIon);
  // SKON disables just like IOF once its skip has been reported.
  assign iot_off     = IOT_EN && ((IOT_OP == OpSkon) || (IOT_OP == OpIof));
  assign iot_clrpend = IOT_EN && (IOT_OP == OpClrpend) && (32'(AC[3:0]) < NCH);

  // Synchroniser chain; stage 0 samples the raw line.
  always_comb begin
    sync_d    = sync_q;
    sync_d[0] = IRQ;
    for (int i = 1; i < int'(SYNC_STAGES); i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  assign sync_out = sync_q[SYNC_STAGES-1];
  assign rise     = sync_out & ~prev_q & EDGE_MASK;

`ifdef IRQ_ARBITER_MASK_EN
  logic [NCH-1:0] mask_q, mask_d;

  always_comb begin
    mask_d = mask_q;
    if (IOT_EN && (IOT_OP == OpLdmask)) begin
      mask_d = AC[NCH-1:0];
    end
  end

  always_ff @(posedge SYSCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      mask_q <= '1;
    end else begin
      mask_q <= mask_d;
    end
  end

  assign mask = mask_q;
`else
  assign mask = '1;
`endif

  logic unused_ac;
  assign unused_ac = ^AC;

  assign pending = ((sticky_q & EDGE_MASK) | (sync_out & ~EDGE_MASK)) & mask;

  // Lowest-index pending channel.
  always_comb begin
    low_idx = '0;
    for (int i = int'(NCH) - 1; i >= 0; i--) begin
      if (pending[i]) begin
        low_idx = 4'(i);
      end
    end
  end

  // Controller: the IOT is applied before the fetch strobe, so IOF beats a take.
  always_comb begin
    state_d = state_q;
    take    = 1'b0;
    unique case (state_q)
      StDisabled: begin
        if (iot_ion) state_d = StArming;
      end
      StArming: begin
        if (iot_off)        state_d = StDisabled;
        else if (STB_FETCH) state_d = StEnabled;
      end
      StEnabled: begin
        if (iot_off) begin
          state_d = StDisabled;
        end else if (STB_FETCH && (|pending)) begin
          state_d = StTaken;
          take    = 1'b1;
        end
      end
      StTaken: begin
        if (STB_FETCH) state_d = StDisabled;
      end
      default: state_d = StDisabled;
    endcase
  end

  // Sticky clears from a take and from CLRPEND; a new edge in the same cycle wins.
  always_comb begin
    clr = '0;
    for (int i = 0; i < int'(NCH); i++) begin
      if ((take && (low_idx == 4'(i))) || (iot_clrpend && (AC[3:0] == 4'(i)))) begin
        clr[i] = 1'b1;
      end
    end
    sticky_d = (sticky_q & ~clr) | rise;
    vector_d = take ? low_idx : vector_q;
    ack_d    = take;
  end

  always_ff @(posedge SYSCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q  <= StDisabled;
      sync_q   <= '0;
      prev_q   <= '0;
      sticky_q <= '0;
      vector_q <= '0;
      ack_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sync_q   <= sync_d;
      prev_q   <= sync_out;
      sticky_q <= sticky_d;
      vector_q <= vector_d;
      ack_q    <= ack_d;
    end
  end

  assign IE           = (state_q == StEnabled);
  assign IRQ_OVERRIDE = (state_q == StTaken);
  assign ACK          = ack_q;
  assign VECTOR       = vector_q;
  assign PENDING      = pending;

  always_comb begin
    SKIP = 1'b0;
    if (IOT_EN && (IOT_OP == OpSkon)) SKIP = IE;
    if (IOT_EN && (IOT_OP == OpSrq))  SKIP = |pending;
  end

  assign DOUT = (IOT_EN && (IOT_OP == OpRdvec)) ? {8'b0, vector_q} : 12'b0;

endmodule

// File: tb/tb_irq_arbiter.sv
module tb_irq_arbiter;

  localparam int unsigned NCH  = 4;
  localparam int unsigned SS   = 2;
  localparam logic [3:0]  EDGE = 4'b0001;

  localparam int MDis = 0;
  localparam int MArm = 1;
  localparam int MEn  = 2;
  localparam int MTak = 3;

  logic        SYSCLK = 1'b0;
  logic        RESET_N = 1'b1;
  logic [3:0]  IRQ = '0;
  logic        IOT_EN = 1'b0;
  logic [2:0]  IOT_OP = '0;
  logic [11:0] AC = '0;
  logic        STB_FETCH = 1'b0;
  logic        IE, IRQ_OVERRIDE, ACK, SKIP;
  logic [3:0]  VECTOR;
  logic [3:0]  PENDING;
  logic [11:0] DOUT;

  int checks = 0;
  int failures = 0;

  irq_arbiter #(
    .NCH        (NCH),
    .SYNC_STAGES(SS),
    .EDGE_MASK  (EDGE)
  ) dut (
    .SYSCLK      (SYSCLK),
    .RESET_N     (RESET_N),
    .IRQ         (IRQ),
    .IOT_EN      (IOT_EN),
    .IOT_OP      (IOT_OP),
    .AC          (AC),
    .STB_FETCH   (STB_FETCH),
    .IE          (IE),
    .IRQ_OVERRIDE(IRQ_OVERRIDE),
    .ACK         (ACK),
    .VECTOR      (VECTOR),
    .PENDING     (PENDING),
    .SKIP        (SKIP),
    .DOUT        (DOUT)
  );

  always #5 SYSCLK = ~SYSCLK;

  // Reference model: controller mode, request history, sticky set, mask, vector.
  int         m_state;
  logic [3:0] m_mask, m_sticky, m_prev, m_vec;
  logic       m_ack;
  logic [3:0] m_hist [SS];  // m_hist[0] is the oldest sample, i.e. the synchronised view

  task automatic m_reset();
    m_state  = MDis;
    m_mask   = 4'hF;
    m_sticky = '0;
    m_prev   = '0;
    m_vec    = '0;
    m_ack    = 1'b0;
    for (int i = 0; i < int'(SS); i++) m_hist[i] = '0;
  endtask

  function automatic logic [3:0] m_pending();
    return ((m_sticky & EDGE) | (m_hist[0] & ~EDGE)) & m_mask;
  endfunction

  function automatic logic m_skip();
    if (!IOT_EN) return 1'b0;
    if (IOT_OP == 3'd0) return (m_state == MEn);
    if (IOT_OP == 3'd3) return |m_pending();
    return 1'b0;
  endfunction

  function automatic logic [11:0] m_dout();
    return (IOT_EN && IOT_OP == 3'd5) ? {8'b0, m_vec} : 12'b0;
  endfunction

  task automatic model_update();
    logic [3:0] pend, cur;
    logic       on, off, take;
    int         idx;
    if (!RESET_N) begin
      m_reset();
      return;
    end
    pend = m_pending();
    cur  = m_hist[0];
    on   = IOT_EN && IOT_OP == 3'd1;
    off  = IOT_EN && (IOT_OP == 3'd0 || IOT_OP == 3'd2);
    take = 1'b0;
    case (m_state)
      MDis: if (on) m_state = MArm;
      MArm: if (off) m_state = MDis; else if (STB_FETCH) m_state = MEn;
      MEn: begin
        if (off) m_state = MDis;
        else if (STB_FETCH && pend != 0) begin
          m_state = MTak;
          take = 1'b1;
        end
      end
      default: if (STB_FETCH) m_state = MDis;
    endcase
    m_ack = take;
    if (take) begin
      idx = -1;
      for (int i = 0; i < int'(NCH); i++) if (idx < 0 && pend[i]) idx = i;
      m_vec = 4'(idx);
      m_sticky[idx] = 1'b0;
    end
    if (IOT_EN && IOT_OP == 3'd6 && int'(AC[3:0]) < int'(NCH)) m_sticky[AC[1:0]] = 1'b0;
    m_sticky = m_sticky | (cur & ~m_prev & EDGE);
`ifdef IRQ_ARBITER_MASK_EN
    if (IOT_EN && IOT_OP == 3'd4) m_mask = AC[3:0];
`endif
    m_prev = cur;
    for (int i = 0; i < int'(SS) - 1; i++) m_hist[i] = m_hist[i+1];
    m_hist[SS-1] = IRQ;
  endtask

  task automatic drive(input logic [3:0] irq, input logic en, input logic [2:0] op,
                       input logic [11:0] ac, input logic stb);
    IRQ = irq; IOT_EN = en; IOT_OP = op; AC = ac; STB_FETCH = stb;
  endtask

  task automatic clk_edge();
    @(posedge SYSCLK);
    model_update();
    @(negedge SYSCLK);
  endtask

  task automatic test_reset();
    RESET_N = 1'b0;
    m_reset();
    drive(4'hF, 1'b1, 3'd5, 12'hFFF, 1'b1);
    clk_edge(); clk_edge();
    checks++; if (IE !== 1'b0) begin failures++; $display("FAIL reset_ie got=%b want=0", IE); end
    checks++; if (IRQ_OVERRIDE !== 1'b0) begin failures++; $display("FAIL reset_ovr got=%b want=0", IRQ_OVERRIDE); end
    checks++; if (ACK !== 1'b0) begin failures++; $display("FAIL reset_ack got=%b want=0", ACK); end
    checks++; if (VECTOR !== 4'd0) begin failures++; $display("FAIL reset_vector got=%0d want=0", VECTOR); end
    checks++; if (PENDING !== 4'd0) begin failures++; $display("FAIL reset_pending got=%b want=0000", PENDING); end
    checks++; if (DOUT !== 12'd0) begin failures++; $display("FAIL reset_dout got=%h want=000", DOUT); end
    drive(4'hF, 1'b1, 3'd3, 12'h0, 1'b0); #1;
    checks++; if (SKIP !== 1'b0) begin failures++; $display("FAIL reset_skip got=%b want=0", SKIP); end
    @(negedge SYSCLK);
    drive(4'h0, 1'b0, 3'd0, 12'h0, 1'b0);
    RESET_N = 1'b1;
    repeat (SS + 1) clk_edge();
  endtask

  task automatic test_ion_delay();
    drive(4'b0000, 1'b1, 3'd1, 12'h0, 1'b0); clk_edge();
    drive(4'b0100, 1'b0, 3'd0, 12'h0, 1'b0); repeat (3) clk_edge();
    checks++; if (PENDING !== 4'b0100) begin failures++; $display("FAIL t1_pending got=%b want=0100", PENDING); end
    checks++; if (IE !== 1'b0) begin failures++; $display("FAIL t1_arming_ie got=%b want=0", IE); end
    drive(4'b0100, 1'b0, 3'd0, 12'h0, 1'b1); clk_edge();
    checks++; if (ACK !== 1'b0 || IRQ_OVERRIDE !== 1'b0) begin
      failures++; $display("FAIL t1_first_fetch got ack=%b ovr=%b want ack=0 ovr=0", ACK, IRQ_OVERRIDE);
    end
    checks++; if (IE !== 1'b1) begin failures++; $display("FAIL t1_enabled_ie got=%b want=1", IE); end
    clk_edge();
    checks++; if (ACK !== 1'b1) begin failures++; $display("FAIL t1_ack got=%b want=1", ACK); end
    checks++; if (VECTOR !== 4'd2) begin failures++; $display("FAIL t1_vector got=%0d want=2", VECTOR); end
    checks++; if (IRQ_OVERRIDE !== 1'b1 || IE !== 1'b0) begin
      failures++; $display("FAIL t1_taken got ovr=%b ie=%b want ovr=1 ie=0", IRQ_OVERRIDE, IE);
    end
    drive(4'b0100, 1'b0, 3'd0, 12'h0, 1'b0); clk_edge();
    checks++; if (ACK !== 1'b0 || IRQ_OVERRIDE !== 1'b1) begin
      failures++; $display("FAIL t1_ack_pulse got ack=%b ovr=%b want ack=0 ovr=1", ACK, IRQ_OVERRIDE);
    end
    drive(4'b0100, 1'b0, 3'd0, 12'h0, 1'b1); clk_edge();
    checks++; if (IRQ_OVERRIDE !== 1'b0 || IE !== 1'b0) begin
      failures++; $display("FAIL t1_return got ovr=%b ie=%b want 0 0", IRQ_OVERRIDE, IE);
    end
    drive(4'b0100, 1'b1, 3'd5, 12'h0, 1'b0); #1;
    checks++; if (DOUT !== 12'd2) begin failures++; $display("FAIL t1_rdvec got=%h want=002", DOUT); end
    clk_edge();
    drive(4'b0000, 1'b0, 3'd0, 12'h0, 1'b0); repeat (3) clk_edge();
  endtask

  task automatic test_priority();
    drive(4'b1010, 1'b0, 3'd0, 12'h0, 1'b0); repeat (3) clk_edge();
    drive(4'b1010, 1'b1, 3'd1, 12'h0, 1'b0); clk_edge();
    drive(4'b1010, 1'b0, 3'd0, 12'h0, 1'b1); clk_edge();
    clk_edge();
    checks++; if (VECTOR !== 4'd1 || ACK !== 1'b1) begin
      failures++; $display("FAIL t2_vector got vec=%0d ack=%b want vec=1 ack=1", VECTOR, ACK);
    end
    clk_edge();
    drive(4'b1010, 1'b1, 3'd3, 12'h0, 1'b0); #1;
    checks++; if (SKIP !== 1'b1) begin failures++; $display("FAIL t2_srq_skip got=%b want=1", SKIP); end
    clk_edge();
    drive(4'b0000, 1'b0, 3'd0, 12'h0, 1'b0); repeat (3) clk_edge();
  endtask

  task automatic test_edge_sticky();
    drive(4'b0001, 1'b0, 3'd0, 12'h0, 1'b0); clk_edge();
    drive(4'b0000, 1'b0, 3'd0, 12'h0, 1'b0); repeat (5) clk_edge();
    checks++; if (PENDING !== 4'b0001) begin failures++; $display("FAIL t3_sticky got=%b want=0001", PENDING); end
    drive(4'b0000, 1'b1, 3'd1, 12'h0, 1'b0); clk_edge();
    drive(4'b0000, 1'b0, 3'd0, 12'h0, 1'b1); clk_edge(); clk_edge();
    checks++; if (ACK !== 1'b1 || VECTOR !== 4'd0) begin
      failures++; $display("FAIL t3_take got ack=%b vec=%0d want ack=1 vec=0", ACK, VECTOR);
    end
    checks++; if (PENDING !== 4'b0000) begin failures++; $display("FAIL t3_cleared got=%b want=0000", PENDING); end
    clk_edge();
    // CLRPEND: out-of-range index leaves the latch alone, index 0 clears it.
    drive(4'b0001, 1'b0, 3'd0, 12'h0, 1'b0); clk_edge();
    drive(4'b0000, 1'b0, 3'd0, 12'h0, 1'b0); repeat (4) clk_edge();
    drive(4'b0000, 1'b1, 3'd6, 12'd9, 1'b0); clk_edge();
    checks++; if (PENDING !== 4'b0001) begin failures++; $display("FAIL clrpend_oob got=%b want=0001", PENDING); end
    drive(4'b0000, 1'b1, 3'd6, 12'd0, 1'b0); clk_edge();
    checks++; if (PENDING !== 4'b0000) begin failures++; $display("FAIL clrpend got=%b want=0000", PENDING); end
    drive(4'b0000, 1'b0, 3'd0, 12'h0, 1'b0); clk_edge();
  endtask

  task automatic test_mask();
    logic [3:0] want_p;
    logic       want_s;
`ifdef IRQ_ARBITER_MASK_EN
    want_p = 4'b0000; want_s = 1'b0;
`else
    want_p = 4'b0010; want_s = 1'b1;
`endif
    drive(4'b0010, 1'b0, 3'd0, 12'h0, 1'b0); repeat (3) clk_edge();
    drive(4'b0010, 1'b1, 3'd4, 12'o0005, 1'b0); clk_edge();
    checks++; if (PENDING !== want_p) begin failures++; $display("FAIL t4_pending got=%b want=%b", PENDING, want_p); end
    drive(4'b0010, 1'b1, 3'd3, 12'h0, 1'b0); #1;
    checks++; if (SKIP !== want_s) begin failures++; $display("FAIL t4_srq got=%b want=%b", SKIP, want_s); end
    clk_edge();
    drive(4'b0010, 1'b1, 3'd4, 12'o7777, 1'b0); clk_edge();
    checks++; if (PENDING !== 4'b0010) begin failures++; $display("FAIL t4_unmask got=%b want=0010", PENDING); end
  endtask

  task automatic test_iof_vs_fetch();
    drive(4'b0010, 1'b1, 3'd1, 12'h0, 1'b0); clk_edge();
    drive(4'b0010, 1'b0, 3'd0, 12'h0, 1'b1); clk_edge();
    checks++; if (IE !== 1'b1) begin failures++; $display("FAIL t5_enabled got=%b want=1", IE); end
    drive(4'b0010, 1'b1, 3'd2, 12'h0, 1'b1); clk_edge();
    checks++; if (IE !== 1'b0 || ACK !== 1'b0 || IRQ_OVERRIDE !== 1'b0) begin
      failures++; $display("FAIL t5_iof_wins got ie=%b ack=%b ovr=%b want 0 0 0", IE, ACK, IRQ_OVERRIDE);
    end
    drive(4'b0010, 1'b0, 3'd0, 12'h0, 1'b1); clk_edge();
    checks++; if (ACK !== 1'b0 || IRQ_OVERRIDE !== 1'b0) begin
      failures++; $display("FAIL t5_stay_off got ack=%b ovr=%b want 0 0", ACK, IRQ_OVERRIDE);
    end
  endtask

  task automatic test_reset_taken();
    drive(4'b0110, 1'b0, 3'd0, 12'h0, 1'b0); repeat (3) clk_edge();
    drive(4'b0110, 1'b1, 3'd4, 12'o0002, 1'b0); clk_edge();
    drive(4'b0110, 1'b1, 3'd1, 12'h0, 1'b0); clk_edge();
    drive(4'b0110, 1'b0, 3'd0, 12'h0, 1'b1); clk_edge(); clk_edge();
    checks++; if (IRQ_OVERRIDE !== 1'b1 || VECTOR !== 4'd1) begin
      failures++; $display("FAIL t6_taken got ovr=%b vec=%0d want ovr=1 vec=1", IRQ_OVERRIDE, VECTOR);
    end
    drive(4'b0110, 1'b0, 3'd0, 12'h0, 1'b0);
    #2;
    RESET_N = 1'b0;
    m_reset();
    #1;
    checks++; if (IRQ_OVERRIDE !== 1'b0 || ACK !== 1'b0 || VECTOR !== 4'd0) begin
      failures++; $display("FAIL t6_async got ovr=%b ack=%b vec=%0d want 0 0 0", IRQ_OVERRIDE, ACK, VECTOR);
    end
    @(negedge SYSCLK);
    RESET_N = 1'b1;
    repeat (3) clk_edge();
    checks++; if (PENDING !== 4'b0110) begin failures++; $display("FAIL t6_mask_ones got=%b want=0110", PENDING); end
    drive(4'b0000, 1'b0, 3'd0, 12'h0, 1'b0); repeat (3) clk_edge();
  endtask

  task automatic test_random();
    logic [3:0]  irq;
    logic        en, stb;
    logic [2:0]  op;
    logic [11:0] ac;
    logic [10:0] got, want;
    irq = '0;
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 3) == 0) irq[$urandom_range(0, 3)] ^= 1'b1;
      en  = ($urandom_range(0, 2) == 0);
      op  = ($urandom_range(0, 2) == 0) ? 3'd1 : 3'($urandom_range(0, 7));
      ac  = 12'($urandom);
      if (op == 3'd4 && $urandom_range(0, 1) == 0) ac[3:0] = 4'hF;
      stb = ($urandom_range(0, 1) == 0);
      drive(irq, en, op, ac, stb); #1;
      checks++; if (SKIP !== m_skip() || DOUT !== m_dout()) begin
        failures++; $display("FAIL rnd_comb n=%0d got skip=%b dout=%h want skip=%b dout=%h",
                             n, SKIP, DOUT, m_skip(), m_dout());
      end
      clk_edge();
      got  = {IE, IRQ_OVERRIDE, ACK, VECTOR, PENDING};
      want = {m_state == MEn, m_state == MTak, m_ack, m_vec, m_pending()};
      checks++; if (got !== want) begin
        failures++; $display("FAIL rnd_state n=%0d got {ie,ovr,ack,vec,pend}=%b want=%b", n, got, want);
      end
    end
  endtask

  initial begin
    m_reset();
    test_reset();
    test_ion_delay();
    test_priority();
    test_edge_sticky();
    test_mask();
    test_iof_vs_fetch();
    test_reset_taken();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
